// File: rtl/change_dispenser.sv
// Coin-return engine: latches the balance on request and pays it out
// greedily, largest coin first, one hopper-acknowledged coin at a time.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-high reset
//   i_return_req    start a payout (sampled in IDLE only)
//   i_current_total balance to return, latched on request
//   i_coin_ack      hopper accepted the coin currently driven
//   o_return_coin   one-hot coin being dispensed, zero otherwise
//   o_return_total  value of the coin accepted this cycle, zero otherwise
//   o_busy          high from request acceptance until DONE is left
//   o_done          one-cycle pulse at the end of a payout
//   o_remainder     amount left unpaid, valid from o_done onwards
//   o_stuck         sticky hopper-timeout flag, cleared on next request
module change_dispenser #(
    parameter int kNumCoins   = 3,
    parameter int kTotalBits  = 31,
    parameter int kCoinVal0   = 100,
    parameter int kCoinVal1   = 500,
    parameter int kCoinVal2   = 1000,
    parameter int kAckTimeout = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_return_req,
    input  logic [kTotalBits-1:0] i_current_total,
    input  logic                  i_coin_ack,
    output logic [kNumCoins-1:0]  o_return_coin,
    output logic [kTotalBits-1:0] o_return_total,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [kTotalBits-1:0] o_remainder,
    output logic                  o_stuck
);

    localparam int kIdxBits = (kNumCoins > 1) ? $clog2(kNumCoins) : 1;

    // Timeout counter compares against the last waiting cycle, so the
    // coin is held for exactly kAckTimeout cycles before aborting.
    localparam logic [7:0] kTmoLast = 8'(kAckTimeout - 1);

    localparam logic [kTotalBits-1:0] kCoinVals [kNumCoins] = '{
        kTotalBits'(kCoinVal0),
        kTotalBits'(kCoinVal1),
        kTotalBits'(kCoinVal2)
    };

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        ISSUE,
        DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [kTotalBits-1:0] remaining_q;
    logic [kTotalBits-1:0] remaining_d;
    logic [kIdxBits-1:0]   coin_idx_q;
    logic [kIdxBits-1:0]   coin_idx_d;
    logic [7:0]            tmo_q;
    logic [7:0]            tmo_d;
    logic [kTotalBits-1:0] remainder_q;
    logic [kTotalBits-1:0] remainder_d;
    logic                  stuck_q;
    logic                  stuck_d;

    logic                  sel_found;
    logic [kIdxBits-1:0]   sel_idx;
    logic [kTotalBits-1:0] cur_val;

    // Greedy selection: values ascend, so the last match is the largest
    // coin that still fits in the remaining balance.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < kNumCoins; k++) begin
            if (kCoinVals[k] <= remaining_q) begin
                sel_found = 1'b1;
                sel_idx   = kIdxBits'(k);
            end
        end
    end

    // Value of the registered coin; explicit mux keeps unused index
    // codes from reading outside the table.
    always_comb begin
        cur_val = '0;
        for (int k = 0; k < kNumCoins; k++) begin
            if (coin_idx_q == kIdxBits'(k)) begin
                cur_val = kCoinVals[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            coin_idx_q  <= '0;
            tmo_q       <= '0;
            remainder_q <= '0;
            stuck_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin_idx_q  <= coin_idx_d;
            tmo_q       <= tmo_d;
            remainder_q <= remainder_d;
            stuck_q     <= stuck_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin_idx_d  = coin_idx_q;
        tmo_d       = tmo_q;
        remainder_d = remainder_q;
        stuck_d     = stuck_q;
        unique case (state_q)
            IDLE: begin
                if (i_return_req) begin
                    remaining_d = i_current_total;
                    remainder_d = '0;
                    stuck_d     = 1'b0;
                    tmo_d       = '0;
                    state_d     = SELECT;
                end
            end
            SELECT: begin
                tmo_d = '0;
                if (sel_found) begin
                    coin_idx_d = sel_idx;
                    state_d    = ISSUE;
                end else begin
                    remainder_d = remaining_q;
                    state_d     = DONE;
                end
            end
            ISSUE: begin
                // An ack in the final waiting cycle still counts the coin.
                if (i_coin_ack) begin
                    remaining_d = remaining_q - cur_val;
                    tmo_d       = '0;
                    state_d     = SELECT;
                end else if (tmo_q == kTmoLast) begin
                    stuck_d     = 1'b1;
                    remainder_d = remaining_q;
                    tmo_d       = '0;
                    state_d     = DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_return_coin  = (state_q == ISSUE)
                          ? (kNumCoins'(1) << coin_idx_q)
                          : '0;
    assign o_return_total = (state_q == ISSUE && i_coin_ack)
                          ? cur_val
                          : '0;
    assign o_busy         = (state_q != IDLE);
    assign o_done         = (state_q == DONE);
    assign o_remainder    = remainder_q;
    assign o_stuck        = stuck_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus random payouts
// checked against a greedy-arithmetic schedule model.
module tb_change_dispenser;

    localparam int kN   = 3;
    localparam int kW   = 31;
    localparam int kTmo = 15;

    logic          clk;
    logic          reset;
    logic          req;
    logic [kW-1:0] total;
    logic          ack;
    logic [kN-1:0] coin;
    logic [kW-1:0] ret_total;
    logic          busy;
    logic          done;
    logic [kW-1:0] remainder;
    logic          stuck;

    int vectors     = 0;
    int miscompares = 0;
    int coin_val [kN] = '{100, 500, 1000};

    change_dispenser dut (
        .clk            (clk),
        .reset          (reset),
        .i_return_req   (req),
        .i_current_total(total),
        .i_coin_ack     (ack),
        .o_return_coin  (coin),
        .o_return_total (ret_total),
        .o_busy         (busy),
        .o_done         (done),
        .o_remainder    (remainder),
        .o_stuck        (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One payout. The model derives the greedy coin list by division and
    // the cycle schedule from per-coin ack delays: request edge -> cycle 1
    // SELECT, each coin spends delay+1 cycles in ISSUE plus one SELECT.
    // tmo_coin: position of a coin whose ack never comes (-1 = none).
    // rst_cycle: cycle in which reset is asserted (0 = none).
    // extra_req: cycle in which a second request is pulsed (0 = none).
    task automatic run(input int amt, input int dmin, input int dmax,
                       input bit ack_high, input int tmo_coin,
                       input int rst_cycle, input int extra_req);
        int idx[$];
        int st[$];
        int ac[$];
        int rem;
        int run_rem;
        int cur;
        int d;
        int last;
        int exp_done;
        int exp_rem;
        int exp_sum;
        int rst_sum;
        int sum;
        bit exp_stuck;
        logic [kN-1:0] e_coin;
        int e_tot;
        bit a;
        rem = amt;
        for (int k = kN - 1; k >= 0; k--) begin
            int n;
            n   = rem / coin_val[k];
            rem = rem % coin_val[k];
            repeat (n) idx.push_back(k);
        end
        exp_rem   = rem;
        exp_stuck = 1'b0;
        exp_sum   = 0;
        run_rem   = amt;
        cur       = 2;
        for (int i = 0; i < idx.size(); i++) begin
            if (i == tmo_coin) d = kTmo;
            else if (ack_high) d = 0;
            else d = $urandom_range(dmax, dmin);
            st.push_back(cur);
            if (d >= kTmo) begin
                ac.push_back(-1);
                cur       = cur + kTmo;
                exp_rem   = run_rem;
                exp_stuck = 1'b1;
                break;
            end
            ac.push_back(cur + d);
            run_rem = run_rem - coin_val[idx[i]];
            exp_sum = exp_sum + coin_val[idx[i]];
            cur     = cur + d + 2;
        end
        exp_done = cur;
        sum      = 0;

        @(negedge clk);
        req   = 1'b1;
        total = kW'(amt);
        @(posedge clk);
        for (int c = 1; c <= exp_done + 1; c++) begin
            if (c > 1) @(posedge clk);
            #1;
            e_coin = '0;
            e_tot  = 0;
            a      = ack_high;
            for (int i = 0; i < st.size(); i++) begin
                last = (ac[i] < 0) ? st[i] + kTmo - 1 : ac[i];
                if (c >= st[i] && c <= last) e_coin = kN'(1 << idx[i]);
                if (ac[i] == c) begin
                    a     = 1'b1;
                    e_tot = coin_val[idx[i]];
                end
            end
            ack   = a;
            req   = (c == extra_req);
            total = (c == extra_req) ? kW'(700) : kW'($urandom);
            if (c == rst_cycle) begin
                rst_sum = 0;
                for (int i = 0; i < ac.size(); i++)
                    if (ac[i] >= 0 && ac[i] < c) rst_sum += coin_val[idx[i]];
                ack   = 1'b0;
                reset = 1'b1;
                #1;
                check("rst_coin", coin, 0);
                check("rst_total", ret_total, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_rem", remainder, 0);
                check("rst_stuck", stuck, 0);
                check("rst_sum", sum, rst_sum);
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                check("rst_idle", busy, 0);
                req = 1'b0;
                return;
            end
            @(negedge clk);
            check("coin", coin, e_coin);
            check("total", ret_total, e_tot);
            check("busy", busy, (c <= exp_done) ? 1 : 0);
            check("done", done, (c == exp_done) ? 1 : 0);
            check("stuck", stuck, (c >= exp_done) ? exp_stuck : 1'b0);
            check("remainder", remainder, (c >= exp_done) ? exp_rem : 0);
            sum = sum + int'(ret_total);
            if (c == exp_done) check("sum", sum, exp_sum);
        end
        ack = 1'b0;
        req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        ack   = 1'b0;
        total = '0;
        #1;
        check("reset_coin", coin, 0);
        check("reset_total", ret_total, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rem", remainder, 0);
        check("reset_stuck", stuck, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run(1600, 0, 0, 1'b1, -1, 0, 0);
        run(0, 0, 0, 1'b0, -1, 0, 0);
        run(250, 0, 0, 1'b1, -1, 0, 0);
        run(500, 0, 0, 1'b0, 0, 0, 0);
        run(100, 0, 0, 1'b0, -1, 0, 0);
        run(1500, 3, 3, 1'b0, -1, 8, 0);
        run(600, 0, 0, 1'b1, -1, 0, 3);
        run(1700, 14, 14, 1'b0, -1, 0, 0);
        run(2600, 1, 2, 1'b0, 1, 0, 0);

        for (int r = 0; r < 24; r++) begin
            int amt;
            int tmo;
            amt = $urandom_range(4000, 0);
            if ($urandom_range(3, 0) == 0) amt = (amt / 100) * 100;
            tmo = ($urandom_range(7, 0) == 0) ? 0 : -1;
            run(amt, 0, 4, 1'b0, tmo, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Sequential coin-return engine for the vending machine: the outgoing-coin counterpart of the coin-input and total logic. On a return request it latches the current balance and pays it out greedily, largest coin first. It drives exactly one coin at a time to the coin hopper and waits for the hopper's acknowledge before issuing the next. Each coin's value is reported back to the balance logic in the cycle it is accepted.

Parameters:
kNumCoins, 3, number of coin denominations.
kTotalBits, 31, width of balance and amount buses.
kCoinVal0, 100, value of coin index 0 (smallest).
kCoinVal1, 500, value of coin index 1.
kCoinVal2, 1000, value of coin index 2 (largest). Values are strictly ascending.
kAckTimeout, 15, cycles to wait for hopper ack before abort (1..255).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
i_return_req  input  1  start payout; sampled in IDLE only.
i_current_total  input  kTotalBits  balance to return; latched when the request is accepted.
i_coin_ack  input  1  hopper accepted the coin currently driven.
o_return_coin  output  kNumCoins  one-hot coin being dispensed; all zero otherwise.
o_return_total  output  kTotalBits  value of the coin accepted this cycle; zero otherwise.
o_busy  output  1  high from request acceptance until DONE is left.
o_done  output  1  one-cycle pulse when payout ends.
o_remainder  output  kTotalBits  amount not payable with the available coins; valid from o_done until the next accepted request.
o_stuck  output  1  sticky flag set on ack timeout; cleared on the next accepted request.

Behaviour:
- Reset, asynchronous, any state: go to IDLE; clear remaining, timeout counter and coin index.
- Reset values: o_return_coin=0, o_return_total=0, o_busy=0, o_done=0, o_remainder=0, o_stuck=0.
- Reset during ISSUE drops the coin immediately; no o_return_total is produced.
- States: IDLE, SELECT, ISSUE, DONE.
- IDLE:
  - i_return_req=1: latch remaining <= i_current_total, clear o_stuck and o_remainder, go to SELECT.
  - i_return_req=0: stay in IDLE.
- SELECT (one cycle):
  - Choose the highest index k with coin value <= remaining, compared as unsigned kTotalBits values.
  - If k exists, register it and go to ISSUE.
  - If no k exists (this includes remaining=0), set o_remainder <= remaining and go to DONE.
- ISSUE:
  - o_return_coin = one-hot(k), held stable until acknowledged.
  - o_return_total is combinational: equals the coin value only in a cycle where state=ISSUE and i_coin_ack=1; zero in every other cycle.
  - On ack: remaining <= remaining - value(k), reset the timeout counter, go to SELECT.
  - Without ack: increment the timeout counter. When it reaches kAckTimeout with no ack, set o_stuck=1 and o_remainder <= remaining (undeducted), then go to DONE.
  - An ack arriving in the timeout cycle wins: the coin is counted and no abort occurs.
- DONE (one cycle): o_done=1, then go to IDLE.
- o_busy = 1 in SELECT, ISSUE and DONE.
- i_return_req while not in IDLE is ignored; it is not queued.
- i_coin_ack outside ISSUE is ignored.
- Latency:
  - Request sampled at edge 0 gives SELECT in cycle 1 and the first coin in cycle 2.
  - With ack in the first ISSUE cycle, each coin costs 2 cycles (ISSUE + SELECT).
- Widths and arithmetic:
  - Coin values are zero-extended to kTotalBits.
  - Subtraction cannot underflow because the selection rule guarantees value <= remaining.
  - All arithmetic is unsigned; there is no wrap-around.
- At most one bit of o_return_coin is high in any cycle.

Test Plan:
- Total 1600, ack tied high, req at cycle 0:
  - o_return_coin = 100b at cycle 2, 010b at cycle 4, 001b at cycle 6.
  - o_return_total = 1000, 500, 100 in those cycles.
  - o_done at cycle 8; o_remainder=0; o_stuck=0.
- Total 0, req:
  - No coin driven; o_done at cycle 2.
  - o_busy high during cycles 1-2; o_remainder=0.
- Total 250, ack high:
  - Two coins of index 0 (100 each).
  - o_remainder=50 at o_done; sum of o_return_total = 200.
- Total 500, ack held low:
  - Coin 010b is held for kAckTimeout=15 cycles.
  - Then o_stuck=1, o_remainder=500, o_done pulses.
  - Next req clears o_stuck.
- Total 1500, ack delayed 3 cycles per coin, reset asserted mid-ISSUE of the second coin:
  - All outputs go to 0 immediately; state is IDLE.
  - Only 1000 was ever reported on o_return_total.
- Second i_return_req (total 700) pulsed while busy paying 600:
  - Ignored; exactly 500 + 100 are dispensed; one o_done.
